keypad_emulator: RTL and testbench

- Synthesizable model of the physical 4x4 matrix keypad: the responder end of the column-scan/row-sense interface driven by the keypad scan controller.
- Accepts "press key K" requests over a valid/ready handshake.
- Watches the active-low column drive and pulls the matching active-low row line low while the key is held, with optional contact bounce on press and release.
- Used on-board for self-test / loopback and in benches as the keypad stand-in.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_key_decode.sv | 14 +
 rtl/keypad_emulator.sv | 161 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad: FSM states and the key map.
// The scan controller should use the same map so both ends agree on
// which column/row a key code sits on.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  // Row lines are active-low; all high means no contact on any row
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Column index per key, packed with key 0xF in the top two bits
  localparam logic [31:0] KEY_COL_MAP = {
    2'd1, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2,
    2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2
  };

  // Row index per key, packed with key 0xF in the top two bits
  localparam logic [31:0] KEY_ROW_MAP = {
    2'd3, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0,
    2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3
  };

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return KEY_COL_MAP[{key, 1'b0} +: 2];
  endfunction

  // Active-low row pattern: only the key's own row bit is pulled low
  function automatic logic [3:0] key_row_pat(input logic [3:0] key);
    logic [1:0] idx;
    idx = KEY_ROW_MAP[{key, 1'b0} +: 2];
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Combinational key-code decode into the column to watch and the row
// pattern to drive when that column is scanned.
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [3:0] key,
  output logic [1:0] col_idx,
  output logic [3:0] row_pat
);

  assign col_idx = key_col(key);
  assign row_pat = key_row_pat(key);

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad. A press request is accepted over
// valid/ready, then the key goes through bounce-in, solid hold, bounce-out
// and a released gap before the next request can be taken. While contact
// is made, the key's row is pulled low whenever its column is scanned.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 32'd8_388_608,
  parameter int unsigned BOUNCE_CYCLES = 32'd0,
  parameter int unsigned BOUNCE_TOGGLE = 32'd4096,
  parameter int unsigned GAP_CYCLES    = 32'd4_194_304,
  parameter int          CNT_W         = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 32'd0);
  localparam bit HAS_GAP    = (GAP_CYCLES != 32'd0);

  localparam int unsigned HOLD_EFF   = (HOLD_CYCLES == 32'd0) ? 32'd1 : HOLD_CYCLES;
  localparam int unsigned TOGGLE_EFF = (BOUNCE_TOGGLE == 32'd0) ? 32'd1 : BOUNCE_TOGGLE;
  localparam int unsigned BOUNCE_EFF = HAS_BOUNCE ? BOUNCE_CYCLES : 32'd1;
  localparam int unsigned GAP_EFF    = HAS_GAP ? GAP_CYCLES : 32'd1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_EFF - 32'd1);
  localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(TOGGLE_EFF - 32'd1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_EFF - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_EFF - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tog;
  logic [3:0]       key_q;
  logic [1:0]       col_idx;
  logic [3:0]       row_pat;

  keypad_key_decode u_decode (
    .key     (key_q),
    .col_idx (col_idx),
    .row_pat (row_pat)
  );

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE);

  // Press sequencer: phase counter, bounce toggling, contact and done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tog     <= '0;
      key_q   <= 4'h0;
      contact <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            key_q   <= req_key;
            cnt     <= '0;
            tog     <= '0;
            contact <= 1'b1;
            if (HAS_BOUNCE) state <= ST_BOUNCE_IN;
            else            state <= ST_HOLD;
          end
        end
        ST_BOUNCE_IN: begin
          if (cnt == BOUNCE_LAST) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            contact <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (tog == TOGGLE_LAST) begin
              tog     <= '0;
              contact <= ~contact;
            end else begin
              tog <= tog + CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            tog     <= '0;
            contact <= 1'b0;
            if (HAS_BOUNCE) begin
              state <= ST_BOUNCE_OUT;
            end else if (HAS_GAP) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_BOUNCE_OUT: begin
          if (cnt == BOUNCE_LAST) begin
            cnt     <= '0;
            contact <= 1'b0;
            if (HAS_GAP) begin
              state <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
            if (tog == TOGGLE_LAST) begin
              tog     <= '0;
              contact <= ~contact;
            end else begin
              tog <= tog + CNT_ONE;
            end
          end
        end
        ST_GAP: begin
          contact <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          tog     <= '0;
          contact <= 1'b0;
        end
      endcase
    end
  end

  // Row sense: pull the key's row low only while contact is made and its column is driven
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= ROW_IDLE;
    end else if (contact && !col[col_idx]) begin
      row <= row_pat;
    end else begin
      row <= ROW_IDLE;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator. Two instances share clock and
// reset: one without bounce for timing/map checks, one with bounce.
module tb_keypad_emulator;

  typedef struct {
    logic       valid;
    logic [3:0] key;
    logic [3:0] col;
  } stim_t;

  typedef struct {
    logic [3:0] row;
    logic       contact;
    logic       busy;
    logic       ready;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  logic       req_valid_a, req_valid_b;
  logic [3:0] req_key_a, req_key_b;
  logic [3:0] col_a, col_b;
  logic       req_ready_a, req_ready_b;
  logic [3:0] row_a, row_b;
  logic       contact_a, contact_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  bit         sel = 1'b0;
  logic [3:0] row_o;
  logic       contact_o, busy_o, ready_o, done_o;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_mis = 0;
  int    acc_a = 0;
  string cur_name = "init";

  keypad_emulator #(
    .HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .GAP_CYCLES(4), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_key(req_key_a),
    .req_ready(req_ready_a), .col(col_a), .row(row_a), .contact(contact_a),
    .busy(busy_a), .done(done_a)
  );

  keypad_emulator #(
    .HOLD_CYCLES(8), .BOUNCE_CYCLES(8), .BOUNCE_TOGGLE(2), .GAP_CYCLES(4), .CNT_W(16)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_key(req_key_b),
    .req_ready(req_ready_b), .col(col_b), .row(row_b), .contact(contact_b),
    .busy(busy_b), .done(done_b)
  );

  assign row_o     = sel ? row_b     : row_a;
  assign contact_o = sel ? contact_b : contact_a;
  assign busy_o    = sel ? busy_b    : busy_a;
  assign ready_o   = sel ? req_ready_b : req_ready_a;
  assign done_o    = sel ? done_b    : done_a;

  // Free-running clock
  always #5 clk = ~clk;

  // Count accepted requests on the non-bounce instance
  always @(posedge clk) begin
    if (reset_n && req_valid_a && req_ready_a) acc_a <= acc_a + 1;
  end

  // Key map written out as it appears on the keypad: one nibble per row, row 0 lowest
  function automatic void ref_lookup(input logic [3:0] key, output int c, output logic [3:0] pat);
    logic [15:0] grid [4];
    grid[0] = 16'hDEBA;
    grid[1] = 16'hF369;
    grid[2] = 16'h0258;
    grid[3] = 16'hC147;
    c   = 0;
    pat = 4'b1111;
    for (int cc = 0; cc < 4; cc++) begin
      for (int r = 0; r < 4; r++) begin
        if (grid[cc][4*r +: 4] == key) begin
          c   = cc;
          pat = 4'b1111 & ~(4'b0001 << r);
        end
      end
    end
  endfunction

  function automatic logic [3:0] col_at(input int mode, input logic [3:0] col_fix, input int c, input int k);
    logic [3:0] v;
    v = col_fix;
    if (mode == 1) begin
      case (k % 5)
        0: v = 4'b1110;
        1: v = 4'b1101;
        2: v = 4'b1011;
        3: v = 4'b0111;
        default: v = 4'b0000;
      endcase
    end else if (mode == 2) begin
      v = 4'b1111 & ~(4'b0001 << ((c + k) % 4));
    end
    return v;
  endfunction

  // Queue one press: stimulus per cycle plus the contact/row/busy/done it should produce
  task automatic push_press(input logic [3:0] key, input int b, input int t, input int h, input int g,
                            input int col_mode, input logic [3:0] col_fix,
                            input bit hold_valid, input logic [3:0] later_key);
    int         c;
    int         len;
    logic [3:0] pat;
    logic       prev;
    logic       cur;
    stim_t      s;
    exp_t       e;
    ref_lookup(key, c, pat);
    len  = 2*b + h + g;
    prev = 1'b0;
    for (int k = 0; k <= len; k++) begin
      s.valid = (k == 0) ? 1'b1 : hold_valid;
      s.key   = (k == 0) ? key : later_key;
      s.col   = col_at(col_mode, col_fix, c, k);
      if (k < b)              cur = ((k / t) % 2) == 0;
      else if (k < b + h)     cur = 1'b1;
      else if (k < 2*b + h)   cur = ((k - b - h) / t) % 2 == 1;
      else                    cur = 1'b0;
      e.contact = cur;
      e.busy    = (k < len);
      e.ready   = (k == len);
      e.done    = (k == len);
      e.row     = (prev && !s.col[c]) ? pat : 4'b1111;
      stim_q.push_back(s);
      exp_q.push_back(e);
      prev = cur;
    end
  endtask

  task automatic push_idle(input int n, input logic [3:0] col);
    stim_t s;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      s.valid = 1'b0; s.key = 4'h0; s.col = col;
      e.row = 4'b1111; e.contact = 1'b0; e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b0;
      stim_q.push_back(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one queued stimulus per cycle and compare against the queued expectation
  task automatic applyStimulus(input int limit);
    stim_t s;
    exp_t  e;
    int    k;
    k = 0;
    while (exp_q.size() > 0 && stim_q.size() > 0 && k < limit) begin
      s = stim_q.pop_front();
      if (sel) begin req_valid_b = s.valid; req_key_b = s.key; col_b = s.col; end
      else     begin req_valid_a = s.valid; req_key_a = s.key; col_a = s.col; end
      @(negedge clk);
      e = exp_q.pop_front();
      checkOutput($sformatf("%s[%0d].row", cur_name, k), row_o, e.row);
      checkOutput($sformatf("%s[%0d].contact", cur_name, k), {3'b0, contact_o}, {3'b0, e.contact});
      checkOutput($sformatf("%s[%0d].busy", cur_name, k), {3'b0, busy_o}, {3'b0, e.busy});
      checkOutput($sformatf("%s[%0d].ready", cur_name, k), {3'b0, ready_o}, {3'b0, e.ready});
      checkOutput($sformatf("%s[%0d].done", cur_name, k), {3'b0, done_o}, {3'b0, e.done});
      k++;
    end
    if (sel) req_valid_b = 1'b0;
    else     req_valid_a = 1'b0;
  endtask

  task automatic check_idle_now(input string tag);
    checkOutput({tag, ".row"}, row_o, 4'b1111);
    checkOutput({tag, ".contact"}, {3'b0, contact_o}, 4'd0);
    checkOutput({tag, ".busy"}, {3'b0, busy_o}, 4'd0);
    checkOutput({tag, ".ready"}, {3'b0, ready_o}, 4'd1);
    checkOutput({tag, ".done"}, {3'b0, done_o}, 4'd0);
  endtask

  initial begin
    int a0;
    reset_n = 1'b0;
    req_valid_a = 1'b0; req_key_a = 4'h0; col_a = 4'b1111;
    req_valid_b = 1'b0; req_key_b = 4'h0; col_b = 4'b1111;

    #12;
    sel = 1'b0; #1 check_idle_now("reset_a");
    sel = 1'b1; #1 check_idle_now("reset_b");
    sel = 1'b0;
    @(negedge clk) reset_n = 1'b1;

    // Reset asserted in the middle of a held key 5
    cur_name = "reset_mid_hold";
    push_press(4'h5, 0, 1, 8, 4, 0, 4'b1011, 1'b0, 4'h0);
    applyStimulus(5);
    stim_q.delete();
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1 check_idle_now("reset_mid_hold.async");
    @(negedge clk) reset_n = 1'b1;
    cur_name = "after_reset";
    push_idle(3, 4'b1011);
    applyStimulus(100);

    // Basic press of key 5 with its column held low
    cur_name = "basic_k5";
    a0 = acc_a;
    push_press(4'h5, 0, 1, 8, 4, 0, 4'b1011, 1'b0, 4'h0);
    push_idle(2, 4'b1011);
    applyStimulus(100);
    checkOutput("basic_k5.accepts", 4'(acc_a - a0), 4'd1);

    // Column selectivity for key F while the scanner walks the columns
    cur_name = "colsel_kF";
    push_press(4'hF, 0, 1, 8, 4, 1, 4'b1111, 1'b0, 4'h0);
    push_idle(1, 4'b1111);
    applyStimulus(100);

    // Bounce on press and release for key A
    sel = 1'b1;
    cur_name = "bounce_kA";
    push_press(4'hA, 8, 2, 8, 4, 0, 4'b1110, 1'b0, 4'h0);
    push_idle(2, 4'b1110);
    applyStimulus(100);
    sel = 1'b0;

    // Valid held through a press; key changes mid-press must not take effect
    cur_name = "handshake";
    a0 = acc_a;
    push_press(4'h1, 0, 1, 8, 4, 0, 4'b0111, 1'b1, 4'hC);
    push_press(4'hC, 0, 1, 8, 4, 0, 4'b0111, 1'b0, 4'h7);
    push_idle(3, 4'b0111);
    applyStimulus(200);
    checkOutput("handshake.accepts", 4'(acc_a - a0), 4'd2);

    // Every key, with the scanner rotating through single columns
    cur_name = "sweep";
    for (int key = 0; key < 16; key++) begin
      push_press(4'(key), 0, 1, 8, 4, 2, 4'b1111, 1'b0, 4'h0);
    end
    push_idle(1, 4'b1111);
    applyStimulus(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
